seq_divider4: RTL
=================

// Module: seq_divider4
// PURPOSE
//   Sequential unsigned restoring divider: quotient = dividend / divisor, remainder = dividend % divisor.
//   It is the inverse of the multiply/accumulate path, built on the add/subtract datapath (M=1 selects subtract).
//   Resolves one quotient bit per clock and uses a start/busy/done handshake.
//   Sits beside the ALU add/sub unit in the lab datapath; the controller launches it with start and waits for done.
// PARAMETERS
//   W  4  operand width (dividend, divisor, quotient, remainder); legal range 2..16
// PORTS
//   clk        in   1  rising-edge clock; the only clock
//   reset      in   1  synchronous, active-high reset
//   start      in   1  launch request; sampled only in IDLE or DONE
//   dividend   in   W  numerator; captured on the accepted start edge
//   divisor    in   W  denominator; captured on the accepted start edge
//   busy       out  1  high while in RUN
//   done       out  1  one-cycle pulse; results valid that cycle and held afterwards
//   quotient   out  W  result quotient
//   remainder  out  W  result remainder
//   div_zero   out  1  divisor was 0 for the last operation
// BEHAVIOUR
//   Reset (sync, active-high, overrides everything): state=IDLE; busy=0, done=0, quotient=0, remainder=0,
//     div_zero=0, count=0. A reset mid-RUN abandons the operation and produces no done pulse.
//   FSM states: IDLE, RUN, DONE.
//     IDLE: start=1 -> capture operands; if divisor==0 -> DONE, else -> RUN with count=W, R=0, Q=dividend.
//     RUN: each cycle, one restoring step (below); count-=1; when count reaches 0 -> DONE.
//     DONE: done=1 for exactly this cycle. start=1 here is accepted as in IDLE (back-to-back);
//       otherwise -> IDLE.
//   Restoring step (R is W+1 bits wide, Q is W bits):
//     {R,Q} shift left by 1, with Q msb entering R lsb.
//     T = R_shifted + ~{1'b0,divisor} + 1, computed with the (W+1)-bit add/sub at M=1.
//     carry-out=1 (no borrow): R=T and Q lsb=1. carry-out=0: R is kept and Q lsb=0.
//   Latency: start accepted at edge k -> RUN in cycles k+1..k+W -> done=1 in cycle k+W+1 (W=4: 5 cycles).
//     Divide by zero: done in cycle k+1.
//   Divide by zero: quotient={W{1'b1}}, remainder=dividend, div_zero=1.
//   Output update: quotient, remainder and div_zero update only on entry to DONE and hold until the next
//     DONE or reset. They never show partial values during RUN. The next accepted start clears div_zero.
//   start during RUN is ignored; no queuing and no error flag.
//   busy=1 exactly in RUN. busy and done are never high together.
//   No overflow is possible: for an unsigned divisor>0, quotient<=dividend and remainder<divisor.
// STRUCTURE
//   Package seq_divider_pkg holds:
//     typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
//     localparam int DIV_W_DEFAULT = 4;
//   One sub-module, addsub_w #(.W(W+1)), inputs (a, b, m), outputs (sum, cout):
//     b is XORed with {W{m}} and m is used as carry-in.
//   The top level holds the FSM, count register, R/Q shift registers and output registers.
//   count width = $clog2(W+1).
// TESTING
//   1 13/4: start at edge k -> done in cycle k+5, quotient=3, remainder=1, div_zero=0; busy high 4 cycles.
//   2 Boundaries: 15/1 -> q=15 r=0; 3/7 -> q=0 r=3; 0/5 -> q=0 r=0; 15/15 -> q=1 r=0.
//   3 9/0 -> done in cycle k+1, quotient=4'hF, remainder=9, div_zero=1; next 6/3 -> q=2 r=0, div_zero=0.
//   4 start pulsed mid-RUN with different operands -> ignored; the original result is returned on schedule.
//   5 reset asserted in the 2nd RUN cycle -> next cycle all outputs 0, state IDLE, no done;
//     a fresh 14/3 -> q=4 r=2.
//   6 start held high through DONE -> back-to-back op accepted, done pulses exactly W+1 cycles apart;
//     exhaustive sweep of all 256 operand pairs against a reference model.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package seq_divider_pkg;

  // Controller states: waiting, iterating one quotient bit per clock, result pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Default operand width for the lab datapath.
  localparam int DIV_W_DEFAULT = 4;

endpackage : seq_divider_pkg

// File: rtl/seq_divider4_addsub_w.sv
// Ripple add/subtract unit: sum = a + (b ^ {W{m}}) + m.
// With m=1 this is a - b, and cout=1 means no borrow (a >= b).
module addsub_w #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         m,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] b_eff;
  logic [W:0]   total;

  // Conditionally invert b; m doubles as the carry-in that completes two's complement.
  always_comb begin
    b_eff = b ^ {W{m}};
    total = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, m};
  end

  assign sum  = total[W-1:0];
  assign cout = total[W];

endmodule : addsub_w

// File: rtl/seq_divider4.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//
// Handshake: start is sampled only in IDLE or DONE; a sampled start captures
// dividend/divisor on that edge. busy is high exactly while iterating (RUN).
// done is a one-cycle pulse in DONE; quotient/remainder/div_zero are valid in
// that cycle and hold until the next DONE or reset. start while busy is ignored.
module seq_divider4
  import seq_divider_pkg::*;
#(
  parameter int W = DIV_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_zero,
  output div_state_t   dbg_state
);

  localparam int CW = $clog2(W + 1);

  div_state_t    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [W:0]    r_q, r_d;          // partial remainder
  logic [W-1:0]  q_q, q_d;          // dividend shifting out / quotient shifting in
  logic [W-1:0]  divisor_q, divisor_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          dz_q, dz_d;

  // Restoring-step datapath.
  logic [W:0]    r_shift;
  logic [W-1:0]  q_shift;
  logic [W:0]    trial;
  logic          no_borrow;
  logic [W:0]    step_r;
  logic [W-1:0]  step_q;

  // The partial remainder stays below the divisor, so its top bit is always
  // zero and is dropped by the shift.
  logic          unused_r_msb;
  assign unused_r_msb = r_q[W];

  // {R,Q} << 1 with the dividend msb moving into the remainder lsb.
  always_comb begin
    r_shift = {r_q[W-1:0], q_q[W-1]};
    q_shift = {q_q[W-2:0], 1'b0};
  end

  addsub_w #(.W(W + 1)) u_addsub (
    .a    (r_shift),
    .b    ({1'b0, divisor_q}),
    .m    (1'b1),
    .sum  (trial),
    .cout (no_borrow)
  );

  // Keep the trial difference only when the subtraction did not borrow.
  always_comb begin
    step_r = no_borrow ? trial : r_shift;
    step_q = {q_shift[W-1:1], no_borrow};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    r_d       = r_q;
    q_d       = q_q;
    divisor_d = divisor_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dz_d      = dz_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          divisor_d = divisor;
          dz_d      = 1'b0;
          if (divisor == '0) begin
            // No iteration needed: report the saturated result immediately.
            state_d = DONE;
            count_d = '0;
            quot_d  = '1;
            rem_d   = dividend;
            dz_d    = 1'b1;
          end else begin
            state_d = RUN;
            count_d = CW'(W);
            r_d     = '0;
            q_d     = dividend;
          end
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        r_d     = step_r;
        q_d     = step_q;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          // Last step: publish the finished result as DONE is entered.
          state_d = DONE;
          quot_d  = step_q;
          rem_d   = step_r[W-1:0];
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, iteration and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      r_q       <= '0;
      q_q       <= '0;
      divisor_q <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      r_q       <= r_d;
      q_q       <= q_d;
      divisor_q <= divisor_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dz_q      <= dz_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;
  assign dbg_state = state_q;

endmodule : seq_divider4
